// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared edge/center-aligned carrier, shadowed configuration and
// per-channel complementary outputs with dead time. Option: PWM_MULTI_PHASE_SHIFT_EN.
module pwm_multi #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pwm_enable,
    input  logic                  mode,
    input  logic [CNT_W-1:0]      period,
    input  logic [N_CH*CNT_W-1:0] duty,
`ifdef PWM_MULTI_PHASE_SHIFT_EN
    input  logic [N_CH*CNT_W-1:0] phase,
`endif
    input  logic [DT_W-1:0]       dead_time,
    input  logic                  ovf_trigger_enable,
    output logic [N_CH-1:0]       pwm,
    output logic [N_CH-1:0]       pwm_cmp,
    output logic                  ovf_trigger,
    output logic [CNT_W-1:0]      counter
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    dir_t                  dir, dir_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CNT_W-1:0]      period_sh;
    logic [N_CH*CNT_W-1:0] duty_sh;
    logic [DT_W-1:0]       dt_sh;
    logic                  mode_sh;
    logic                  idle;
    logic                  carrier_evt;
    logic [CNT_W-1:0]      cmp_cnt;
    logic [N_CH-1:0]       ref_cur;
    logic [N_CH-1:0]       ref_prev;
    logic [DT_W-1:0]       dt_cnt [N_CH];
`ifdef PWM_MULTI_PHASE_SHIFT_EN
    logic [N_CH*CNT_W-1:0] phase_sh;
    logic [CNT_W-1:0]      ph;
    logic [CNT_W:0]        ph_sum;
`endif

    assign idle = !pwm_enable || (period_sh == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            dir     <= DIR_UP;
        end else begin
            counter <= cnt_nxt;
            dir     <= dir_nxt;
        end
    end

    always_comb begin
        cnt_nxt = counter + CNT_ONE;
        dir_nxt = dir;
        if (idle || carrier_evt) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (mode_sh && dir == DIR_DOWN) begin
            cnt_nxt = counter - CNT_ONE;
        end else if (mode_sh && (counter + CNT_ONE >= period_sh)) begin
            dir_nxt = DIR_DOWN;
        end
    end

    // Carrier event: edge-mode wrap, or the 1->0 valley step of the triangle.
    always_comb begin
        carrier_evt = 1'b0;
        if (!idle) begin
            if (mode_sh) carrier_evt = (dir == DIR_DOWN) && (counter <= CNT_ONE);
            else         carrier_evt = (counter >= period_sh - CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_sh   <= '0;
            duty_sh     <= '0;
            dt_sh       <= '0;
            mode_sh     <= 1'b0;
            ovf_trigger <= 1'b0;
`ifdef PWM_MULTI_PHASE_SHIFT_EN
            phase_sh    <= '0;
`endif
        end else begin
            ovf_trigger <= carrier_evt && ovf_trigger_enable;
            if (idle || carrier_evt) begin
                period_sh <= period;
                duty_sh   <= duty;
                dt_sh     <= dead_time;
                mode_sh   <= mode;
`ifdef PWM_MULTI_PHASE_SHIFT_EN
                phase_sh  <= phase;
`endif
            end
        end
    end

    always_comb begin
        ref_cur = '0;
        cmp_cnt = counter;
`ifdef PWM_MULTI_PHASE_SHIFT_EN
        ph      = '0;
        ph_sum  = '0;
`endif
        for (int unsigned i = 0; i < N_CH; i++) begin
            cmp_cnt = counter;
`ifdef PWM_MULTI_PHASE_SHIFT_EN
            if (!mode_sh) begin
                ph = phase_sh[i*CNT_W +: CNT_W];
                if (ph >= period_sh) ph = '0;
                ph_sum = {1'b0, counter} + {1'b0, ph};
                if (ph_sum >= {1'b0, period_sh}) ph_sum = ph_sum - {1'b0, period_sh};
                cmp_cnt = ph_sum[CNT_W-1:0];
            end
`endif
            ref_cur[i] = cmp_cnt < duty_sh[i*CNT_W +: CNT_W];
        end
    end

    // A ref toggle drops both sides; the new side turns on once dt_cnt runs out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm      <= '0;
            pwm_cmp  <= '0;
            ref_prev <= '0;
            for (int unsigned i = 0; i < N_CH; i++) dt_cnt[i] <= '0;
        end else if (idle) begin
            pwm      <= '0;
            pwm_cmp  <= '0;
            ref_prev <= '0;
            for (int unsigned i = 0; i < N_CH; i++) dt_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                ref_prev[i] <= ref_cur[i];
                if ((ref_cur[i] != ref_prev[i]) && (dt_sh != '0)) begin
                    pwm[i]     <= 1'b0;
                    pwm_cmp[i] <= 1'b0;
                    dt_cnt[i]  <= dt_sh;
                end else if ((ref_cur[i] == ref_prev[i]) && (dt_cnt[i] > DT_ONE)) begin
                    pwm[i]     <= 1'b0;
                    pwm_cmp[i] <= 1'b0;
                    dt_cnt[i]  <= dt_cnt[i] - DT_ONE;
                end else begin
                    pwm[i]     <= ref_cur[i];
                    pwm_cmp[i] <= !ref_cur[i];
                    dt_cnt[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a carrier-phase reference model checked every cycle, plus
// directed pulse-width, dead-time, shadowing, enable and reset scenarios.
module tb_pwm_multi;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           pwm_enable = 1'b0;
    logic           mode = 1'b0;
    logic [W-1:0]   period = '0;
    logic [N*W-1:0] duty = '0;
    logic [D-1:0]   dead_time = '0;
    logic           ovf_trigger_enable = 1'b0;
`ifdef PWM_MULTI_PHASE_SHIFT_EN
    logic [N*W-1:0] phase = '0;
`endif
    logic [N-1:0]   pwm;
    logic [N-1:0]   pwm_cmp;
    logic           ovf_trigger;
    logic [W-1:0]   counter;

    int vectors = 0;
    int miscompares = 0;

    pwm_multi #(.N_CH(N), .CNT_W(W), .DT_W(D)) dut (
        .clk(clk), .reset(reset), .pwm_enable(pwm_enable), .mode(mode),
        .period(period), .duty(duty),
`ifdef PWM_MULTI_PHASE_SHIFT_EN
        .phase(phase),
`endif
        .dead_time(dead_time), .ovf_trigger_enable(ovf_trigger_enable),
        .pwm(pwm), .pwm_cmp(pwm_cmp), .ovf_trigger(ovf_trigger), .counter(counter)
    );

    always #5 clk = ~clk;

    // Reference model: position t within the carrier; ref history kept as run length.
    int           m_t = 0;
    int           m_p = 0;
    int           m_dt = 0;
    bit           m_mode = 1'b0;
    int           m_duty [N];
    int           m_ph [N];
    bit           run_val [N];
    int           run_len [N];
    logic [N-1:0] e_pwm = '0;
    logic [N-1:0] e_cmp = '0;
    logic         e_ovf = 1'b0;
    logic [W-1:0] e_cnt = '0;

    function automatic int carrier_len(bit md, int p);
        return md ? 2 * p : p;
    endfunction

    function automatic int count_at(bit md, int p, int t);
        return (md && t > p) ? 2 * p - t : t;
    endfunction

    function automatic void model_load();
        m_p    = int'(period);
        m_dt   = int'(dead_time);
        m_mode = mode;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = int'(duty[i*W +: W]);
`ifdef PWM_MULTI_PHASE_SHIFT_EN
            m_ph[i] = int'(phase[i*W +: W]);
`else
            m_ph[i] = 0;
`endif
        end
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit idle;
        bit last;
        bit r;
        int c;
        int cc;
        if (!reset) begin
            m_t = 0; m_p = 0; m_dt = 0; m_mode = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_duty[i] = 0; m_ph[i] = 0; run_val[i] = 1'b0; run_len[i] = 1000;
            end
            e_pwm = '0; e_cmp = '0; e_ovf = 1'b0; e_cnt = '0;
        end else begin
            idle = !pwm_enable || m_p == 0;
            last = !idle && (m_t == carrier_len(m_mode, m_p) - 1);
            c = count_at(m_mode, m_p, m_t);
            for (int i = 0; i < N; i++) begin
                cc = c;
                if (!m_mode && m_ph[i] < m_p) cc = (c + m_ph[i]) % m_p;
                r = cc < m_duty[i];
                if (idle) begin
                    run_val[i] = 1'b0; run_len[i] = 1000;
                    e_pwm[i] = 1'b0;   e_cmp[i] = 1'b0;
                end else begin
                    if (r == run_val[i]) begin
                        if (run_len[i] < 1000) run_len[i]++;
                    end else begin
                        run_val[i] = r; run_len[i] = 1;
                    end
                    e_pwm[i] = run_val[i] && run_len[i] > m_dt;
                    e_cmp[i] = !run_val[i] && run_len[i] > m_dt;
                end
            end
            e_ovf = last && ovf_trigger_enable;
            if (idle || last) begin
                m_t = 0;
                model_load();
            end else begin
                m_t++;
            end
            e_cnt = W'(count_at(m_mode, m_p, m_t));
        end
    end

    task automatic set_duty(input int ch, input int val);
        duty[ch*W +: W] = W'(val);
    endtask

    task automatic configure(input bit md, input int p, input int dt);
        @(negedge clk);
        pwm_enable = 1'b0; mode = md; period = W'(p); dead_time = D'(dt);
        ovf_trigger_enable = 1'b1;
        @(negedge clk);
        pwm_enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pwm_enable = 1'b1; period = W'(10); set_duty(0, 3);
        ovf_trigger_enable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({pwm, pwm_cmp, ovf_trigger, counter} !== '0) begin
                miscompares++;
                $display("FAIL reset_state: pwm=%b cmp=%b ovf=%b cnt=%0d, expected all zero",
                         pwm, pwm_cmp, ovf_trigger, counter);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_edge_basic(input int dt, input int exp_hi, input int exp_cmp_hi);
        int hi = 0, cmp_hi = 0, trig = 0;
        for (int i = 1; i < N; i++) set_duty(i, int'($urandom_range(0, 11)));
        set_duty(0, 3);
        configure(1'b0, 10, dt);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            vectors++;
            if ({pwm, pwm_cmp, ovf_trigger, counter} !== {e_pwm, e_cmp, e_ovf, e_cnt}) begin
                miscompares++;
                $display("FAIL edge_model dt=%0d n=%0d: pwm=%b cmp=%b ovf=%b cnt=%0d, exp %b %b %b %0d",
                         dt, n, pwm, pwm_cmp, ovf_trigger, counter, e_pwm, e_cmp, e_ovf, e_cnt);
            end
            vectors++;
            if ((pwm & pwm_cmp) !== '0) begin
                miscompares++;
                $display("FAIL edge_overlap n=%0d: pwm=%b cmp=%b, required no common 1", n, pwm, pwm_cmp);
            end
            if (n >= 30) begin
                hi += int'(pwm[0]); cmp_hi += int'(pwm_cmp[0]); trig += int'(ovf_trigger);
            end
        end
        vectors++;
        if (hi != exp_hi || cmp_hi != exp_cmp_hi || trig != 1) begin
            miscompares++;
            $display("FAIL edge_width dt=%0d: pwm_hi=%0d cmp_hi=%0d trig=%0d, expected %0d %0d 1",
                     dt, hi, cmp_hi, trig, exp_hi, exp_cmp_hi);
        end
    endtask

    task automatic test_shadow();
        int hi;
        bit found = 1'b0;
        set_duty(0, 3);
        configure(1'b0, 10, 0);
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (e_cnt == W'(5) && n > 3) begin
                found = 1'b1;
                set_duty(0, 7);
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL shadow_wait: counter=5 not reached, required within 30 cycles");
        end
        hi = 0;
        repeat (5) begin @(negedge clk); hi += int'(pwm[0]); end
        vectors++;
        if (hi != 0) begin
            miscompares++;
            $display("FAIL shadow_current: pwm_hi=%0d in rest of period, expected 0", hi);
        end
        hi = 0;
        repeat (10) begin @(negedge clk); hi += int'(pwm[0]); end
        vectors++;
        if (hi != 7) begin
            miscompares++;
            $display("FAIL shadow_next: pwm_hi=%0d in next period, expected 7", hi);
        end
        for (int k = 0; k < 2; k++) begin
            int c_hi = 0;
            set_duty(0, k == 0 ? 0 : 500);
            repeat (20) @(negedge clk);
            hi = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                hi += int'(pwm[0]); c_hi += int'(pwm_cmp[0]);
                vectors++;
                if ({pwm, pwm_cmp, ovf_trigger, counter} !== {e_pwm, e_cmp, e_ovf, e_cnt}) begin
                    miscompares++;
                    $display("FAIL extreme_model k=%0d: pwm=%b cmp=%b cnt=%0d, exp %b %b %0d",
                             k, pwm, pwm_cmp, counter, e_pwm, e_cmp, e_cnt);
                end
            end
            vectors++;
            if (hi != (k == 0 ? 0 : 10) || c_hi != (k == 0 ? 10 : 0)) begin
                miscompares++;
                $display("FAIL duty_extreme k=%0d: pwm_hi=%0d cmp_hi=%0d, expected %0d %0d",
                         k, hi, c_hi, k == 0 ? 0 : 10, k == 0 ? 10 : 0);
            end
        end
    endtask

    task automatic test_center();
        int trig = 0, hi = 0;
        set_duty(1, 4);
        configure(1'b1, 8, 2);
        for (int n = 0; n < 48; n++) begin
            @(negedge clk);
            vectors++;
            if ({pwm, pwm_cmp, ovf_trigger, counter} !== {e_pwm, e_cmp, e_ovf, e_cnt}) begin
                miscompares++;
                $display("FAIL center_model n=%0d: pwm=%b cmp=%b ovf=%b cnt=%0d, exp %b %b %b %0d",
                         n, pwm, pwm_cmp, ovf_trigger, counter, e_pwm, e_cmp, e_ovf, e_cnt);
            end
            if (n >= 32) trig += int'(ovf_trigger);
        end
        vectors++;
        if (trig != 1) begin
            miscompares++;
            $display("FAIL center_carrier: %0d triggers in 16 cycles, expected 1", trig);
        end
        set_duty(1, 1);
        configure(1'b1, 8, 3);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n >= 8) hi += int'(pwm[1]);
        end
        vectors++;
        if (hi != 0) begin
            miscompares++;
            $display("FAIL center_swallow: pwm[1] high %0d cycles, expected 0", hi);
        end
    endtask

    task automatic test_disable();
        bit found = 1'b0;
        int trig = 0;
        set_duty(0, 4);
        configure(1'b0, 10, 1);
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (e_cnt == W'(6) && n > 3) found = 1'b1;
        end
        pwm_enable = 1'b0; ovf_trigger_enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (!found || {pwm, pwm_cmp, ovf_trigger, counter} !== '0) begin
            miscompares++;
            $display("FAIL disable_stop: found=%0d pwm=%b cmp=%b ovf=%b cnt=%0d, expected 1 and zeros",
                     found, pwm, pwm_cmp, ovf_trigger, counter);
        end
        pwm_enable = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            vectors++;
            if (counter !== W'(n)) begin
                miscompares++;
                $display("FAIL restart_count: counter=%0d, expected %0d", counter, n);
            end
        end
        repeat (30) begin @(negedge clk); trig += int'(ovf_trigger); end
        vectors++;
        if (trig != 0) begin
            miscompares++;
            $display("FAIL trig_gated: %0d pulses with trigger disabled, expected 0", trig);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int p = int'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) p = 0;
            for (int i = 0; i < N; i++) set_duty(i, int'($urandom_range(0, 23)));
            configure(1'($urandom_range(0, 1)), p, int'($urandom_range(0, 4)));
            ovf_trigger_enable = 1'($urandom_range(0, 1));
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                vectors++;
                if ({pwm, pwm_cmp, ovf_trigger, counter} !== {e_pwm, e_cmp, e_ovf, e_cnt}) begin
                    miscompares++;
                    $display("FAIL random_model k=%0d n=%0d: pwm=%b cmp=%b ovf=%b cnt=%0d, exp %b %b %b %0d",
                             k, n, pwm, pwm_cmp, ovf_trigger, counter, e_pwm, e_cmp, e_ovf, e_cnt);
                end
                vectors++;
                if ((pwm & pwm_cmp) !== '0) begin
                    miscompares++;
                    $display("FAIL random_overlap k=%0d: pwm=%b cmp=%b, required no common 1",
                             k, pwm, pwm_cmp);
                end
                if ($urandom_range(0, 9) == 0) begin
                    period = W'($urandom_range(1, 20));
                    mode = 1'($urandom_range(0, 1));
                    set_duty(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 23)));
                end
            end
        end
    endtask

`ifdef PWM_MULTI_PHASE_SHIFT_EN
    task automatic test_phase();
        logic hist [$];
        for (int i = 0; i < N; i++) set_duty(i, 5);
        phase = '0;
        phase[W +: W] = W'(5);
        configure(1'b0, 10, 0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            hist.push_back(pwm[0]);
            if (n >= 10) begin
                vectors++;
                if (pwm[1] !== hist[n - 5]) begin
                    miscompares++;
                    $display("FAIL phase_shift n=%0d: pwm[1]=%b, expected %b", n, pwm[1], hist[n - 5]);
                end
            end
        end
        phase = '0;
    endtask
`endif

    task automatic test_async_reset();
        set_duty(0, 5);
        configure(1'b0, 10, 0);
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({pwm, pwm_cmp, ovf_trigger, counter} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: pwm=%b cmp=%b ovf=%b cnt=%0d, expected all zero before edge",
                     pwm, pwm_cmp, ovf_trigger, counter);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_edge_basic(0, 3, 7);
        test_edge_basic(1, 2, 6);
        test_shadow();
        test_center();
        test_disable();
        test_random();
`ifdef PWM_MULTI_PHASE_SHIFT_EN
        test_phase();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
